source_arbiter: RTL and testbench
=================================

Name: source_arbiter

Overview:
- Round-robin arbiter directly upstream of the one-hot byte muxer. It picks one of NUM show-ahead source FIFOs and drives the muxer's one-hot enable bus.
- It pops the selected FIFO one word per accepted transfer and frames each grant as a burst with a valid/first-word qualifier for the downstream consumer.
- Muxer data_out is valid exactly when out_valid is high.

Parameters:
- NUM, 4, number of sources; equals the muxer's NUM.
- MAX_BURST, 16, maximum words per grant when the burst limit is compiled in; range 1..2^BURST_W-1.
- BURST_W, 5, width of the burst counter and of burst_len.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- req  input  NUM  per-source "data available" (show-ahead FIFO not-empty); the source's data is valid while req[i]=1.
- ready  input  1  downstream can accept a word this cycle.
- rdreq  output  NUM  one-hot pop strobe to the granted source FIFO.
- ena_bus  output  NUM  one-hot grant, wired to the muxer ena_in_bus; registered.
- out_valid  output  1  a word is transferred this cycle (OR of rdreq).
- out_sop  output  1  first word of the current burst.
- burst_done  output  1  one-cycle pulse in the cycle after a grant is released.
- burst_len  output  BURST_W  words moved in the burst just released; valid while burst_done=1, held otherwise.

Behaviour:
- Reset values (asynchronous on rst=1):
  - state=IDLE, ena_bus=0, rdreq=0, out_valid=0, out_sop=0, burst_done=0.
  - burst_len=0, counter=0, round-robin pointer=0.
- Reset mid-burst: the grant drops immediately, no further pops occur, the counter clears, and the pointer returns to 0.
- IDLE state:
  - If req!=0, choose the first i with req[i]=1, searching from index ptr upward with wrap-around (ptr, ptr+1, ..., NUM-1, 0, ...).
  - Register ena_bus=one-hot(i), clear the counter, set the first-word flag, and go to BUSY.
  - If req=0, stay in IDLE with ena_bus=0.
- Grant latency: 1 clock from req rising (in IDLE) to ena_bus asserted. The earliest transfer happens in the cycle ena_bus is high.
- BUSY state, with granted index g:
  - Transfer condition: req[g] & ready. rdreq[g]=1 and out_valid=1 combinationally in that cycle; all other rdreq bits are 0.
  - out_sop=1 on the first transfer of the burst only. It stays low on ready stalls until that first word moves.
  - The counter increments on each transfer and saturates at 2^BURST_W-1.
- Release conditions, evaluated at the clock edge in BUSY:
  - (a) req[g]=0, i.e. the source has emptied. No transfer happens that cycle.
  - (b) The burst limit is reached; see Optional Feature.
  - On release: ena_bus<=0, ptr<=(g+1) mod NUM, burst_len<=counter including any transfer in that cycle, burst_done<=1 for 1 cycle, state<=IDLE.
- Turnaround: at least 1 idle cycle (ena_bus=0) between bursts, even if other requests are pending. This guarantees the muxer sees no overlap.
- A ready stall (ready=0) while req[g]=1 does not cause release; the grant is held indefinitely.
- Requests from non-granted sources are ignored until IDLE.
- NUM=1: the pointer is always 0 and bursts repeat with 1-cycle gaps.
- ena_bus is always zero or one-hot; rdreq is always a subset of ena_bus.

Optional Feature:
- Macro: BURST_LIMIT_EN.
- Defined:
  - A burst also releases on the clock edge where a transfer brings the counter to MAX_BURST.
  - Release reason (b) applies.
  - Guarantees fairness under continuous requests.
- Not defined:
  - Only reason (a) releases a grant, so a source holds the muxer until it empties.
  - MAX_BURST is unused. burst_len saturates at 2^BURST_W-1.

Test Plan:
- Reset/basic: assert rst mid-run with req=4'b0100, ready=1 → ena_bus=0 and rdreq=0 the same cycle. After release of rst: ena_bus=4'b0001 one cycle after req=4'b0001.
- Drain: source 2 holds 3 words (req[2] drops after the 3rd pop), ready=1 → rdreq[2] high 3 cycles, out_sop on word 1 only, burst_done pulse with burst_len=3, then ena_bus=0 for ≥1 cycle.
- Round-robin: req=4'b1111 constant, each source 1 word then drop → grant order 0,1,2,3,0 with 1 idle cycle between grants.
- Backpressure: granted source 1, ready toggles 1,0,0,1,1 → exactly 3 pops, out_valid coincides with ready=1, no release during stalls.
- Burst limit, with BURST_LIMIT_EN and MAX_BURST=4: req=4'b0011 continuous → source 0 moves 4 words, burst_len=4, then source 1 is granted. Without the macro: source 0 keeps the grant until req[0] drops.
- Wrap/sparse: ptr=3 after a source-2 burst, req=4'b0001 only → source 0 granted; ptr=1 afterwards.

Source files
------------

// File: rtl/source_arbiter.sv
// Round-robin arbiter: grants one of NUM show-ahead FIFOs to the one-hot byte muxer, one burst per grant.
// Define BURST_LIMIT_EN to also end a grant once MAX_BURST words have moved.
module source_arbiter #(
  parameter int NUM       = 4,
  parameter int MAX_BURST = 16,
  parameter int BURST_W   = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM-1:0]     req,
  input  logic               ready,
  output logic [NUM-1:0]     rdreq,
  output logic [NUM-1:0]     ena_bus,
  output logic               out_valid,
  output logic               out_sop,
  output logic               burst_done,
  output logic [BURST_W-1:0] burst_len
);

  localparam int PTR_W = (NUM > 1) ? $clog2(NUM) : 1;
`ifdef BURST_LIMIT_EN
  localparam bit LIMIT_EN = 1'b1;
`else
  localparam bit LIMIT_EN = 1'b0;
`endif

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  state_t             r_state, w_state;
  logic [NUM-1:0]     r_ena, w_ena;
  logic [PTR_W-1:0]   r_grant, w_grant;
  logic [PTR_W-1:0]   r_ptr, w_ptr;
  logic [BURST_W-1:0] r_cnt, w_cnt;
  logic [BURST_W-1:0] r_len, w_len;
  logic               r_first, w_first;
  logic               r_done, w_done;

  logic               w_req_g, w_xfer, w_limit, w_found_hi;
  logic [BURST_W-1:0] w_cnt_inc;
  logic [PTR_W-1:0]   w_pick, w_pick_hi, w_pick_lo, w_ptr_nxt;
  logic [NUM-1:0]     w_onehot;

  // r_ena is zero outside BUSY, so masking with it selects req[g] only
  assign w_req_g   = |(req & r_ena);
  assign w_xfer    = w_req_g & ready;
  assign w_cnt_inc = (w_xfer && (r_cnt != '1)) ? r_cnt + BURST_W'(1) : r_cnt;
  assign w_limit   = LIMIT_EN && w_xfer && (w_cnt_inc == BURST_W'(MAX_BURST));
  assign w_ptr_nxt = (r_grant == PTR_W'(NUM - 1)) ? '0 : r_grant + PTR_W'(1);

  // Wrap-around search: lowest requester at or above ptr, else lowest overall
  always_comb begin
    w_found_hi = 1'b0;
    w_pick_hi  = '0;
    w_pick_lo  = '0;
    for (int i = NUM - 1; i >= 0; i--) begin
      if (req[i]) w_pick_lo = PTR_W'(i);
      if (req[i] && (PTR_W'(i) >= r_ptr)) begin
        w_pick_hi  = PTR_W'(i);
        w_found_hi = 1'b1;
      end
    end
    w_pick = w_found_hi ? w_pick_hi : w_pick_lo;
    for (int i = 0; i < NUM; i++) w_onehot[i] = (PTR_W'(i) == w_pick);
  end

  always_comb begin
    w_state = r_state;
    w_ena   = r_ena;
    w_grant = r_grant;
    w_ptr   = r_ptr;
    w_cnt   = r_cnt;
    w_len   = r_len;
    w_first = r_first;
    w_done  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (|req) begin
          w_ena   = w_onehot;
          w_grant = w_pick;
          w_cnt   = '0;
          w_first = 1'b1;
          w_state = S_BUSY;
        end
      end
      S_BUSY: begin
        if (!w_req_g || w_limit) begin
          w_ena   = '0;
          w_ptr   = w_ptr_nxt;
          w_len   = w_cnt_inc;
          w_cnt   = w_cnt_inc;
          w_done  = 1'b1;
          w_state = S_IDLE;
        end else begin
          w_cnt = w_cnt_inc;
          if (w_xfer) w_first = 1'b0;
        end
      end
      default: w_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_ena   <= '0;
      r_grant <= '0;
      r_ptr   <= '0;
      r_cnt   <= '0;
      r_len   <= '0;
      r_first <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state;
      r_ena   <= w_ena;
      r_grant <= w_grant;
      r_ptr   <= w_ptr;
      r_cnt   <= w_cnt;
      r_len   <= w_len;
      r_first <= w_first;
      r_done  <= w_done;
    end
  end

  assign ena_bus    = r_ena;
  assign rdreq      = r_ena & req & {NUM{ready}};
  assign out_valid  = |rdreq;
  assign out_sop    = r_first & out_valid;
  assign burst_done = r_done;
  assign burst_len  = r_len;

endmodule

// File: tb/tb_source_arbiter.sv
// Bench for source_arbiter: FIFO-backed directed stimulus, per-cycle model compare and literal checks.
module tb_source_arbiter;
  localparam int NUM   = 4;
  localparam int MAX_B = 4;
  localparam int BW    = 5;
`ifdef BURST_LIMIT_EN
  localparam bit LIM = 1'b1;
`else
  localparam bit LIM = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [NUM-1:0] req = '0;
  logic           ready = 1'b0;
  logic [NUM-1:0] rdreq, ena_bus;
  logic           out_valid, out_sop, burst_done;
  logic [BW-1:0]  burst_len;

  source_arbiter #(.NUM(NUM), .MAX_BURST(MAX_B), .BURST_W(BW)) dut (
    .clk(clk), .rst(rst), .req(req), .ready(ready), .rdreq(rdreq), .ena_bus(ena_bus),
    .out_valid(out_valid), .out_sop(out_sop), .burst_done(burst_done), .burst_len(burst_len)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0, cyc = 0;
  int fifo[NUM];
  int pop_cnt[NUM];
  int sop_cnt = 0, done_cnt = 0;
  int g_idx[$], g_cyc[$], lens[$];
  logic [NUM-1:0] popped = '0, prev_ena = '0;

  // Model: owner=-1 means no grant; words moved, first-word pending, ptr, last release
  int m_owner = -1, m_words = 0, m_ptr = 0, m_len = 0, m_k = 0;
  bit m_sop = 1'b0, m_done = 1'b0;
  logic [NUM-1:0] e_ena, e_rd;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic m_release();
    m_len   = m_words;
    m_done  = 1'b1;
    m_ptr   = (m_owner + 1) % NUM;
    m_owner = -1;
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_owner = -1; m_words = 0; m_ptr = 0; m_len = 0; m_sop = 1'b0; m_done = 1'b0;
    end else begin
      m_done = 1'b0;
      if (m_owner < 0) begin
        if (req != '0) begin
          m_k = 0;
          while (((req >> ((m_ptr + m_k) % NUM)) & NUM'(1)) == '0) m_k++;
          m_owner = (m_ptr + m_k) % NUM;
          m_words = 0;
          m_sop   = 1'b1;
        end
      end else if (((req >> m_owner) & NUM'(1)) == '0) begin
        m_release();
      end else if (ready) begin
        if (m_words < (2 ** BW) - 1) m_words++;
        m_sop = 1'b0;
        if (LIM && m_words == MAX_B) m_release();
      end
    end
  end

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    e_ena = (m_owner >= 0) ? (NUM'(1) << m_owner) : '0;
    e_rd  = (m_owner >= 0 && ((req >> m_owner) & NUM'(1)) != '0 && ready) ? e_ena : '0;
    chk("ena_bus", 32'(ena_bus), 32'(e_ena));
    chk("rdreq", 32'(rdreq), 32'(e_rd));
    chk("out_valid", 32'(out_valid), 32'(e_rd != '0));
    chk("out_sop", 32'(out_sop), 32'(m_sop && e_rd != '0));
    chk("burst_done", 32'(burst_done), 32'(m_done));
    chk("burst_len", 32'(burst_len), 32'(m_len));
    popped = rdreq;
    for (int i = 0; i < NUM; i++) if (rdreq[i]) pop_cnt[i]++;
    if (out_sop) sop_cnt++;
    if (burst_done) begin
      done_cnt++;
      lens.push_back(int'(burst_len));
    end
    if (ena_bus != '0 && prev_ena == '0) begin
      for (int i = 0; i < NUM; i++) if (ena_bus[i]) g_idx.push_back(i);
      g_cyc.push_back(cyc);
    end
    prev_ena = ena_bus;
  end

  task automatic drive_req();
    for (int i = 0; i < NUM; i++) req[i] = (fifo[i] > 0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    for (int i = 0; i < NUM; i++) if (popped[i] && fifo[i] > 0) fifo[i]--;
    drive_req();
  endtask

  task automatic wait_done(input int target, input int budget, input string name);
    int n;
    n = 0;
    while (done_cnt < target && n < budget) begin
      tick();
      n++;
    end
    chk(name, 32'(done_cnt >= target), 32'd1);
  endtask

  int gb, lb, d0, pc;
  int bp_pat[5] = '{1, 0, 0, 1, 1};

  initial begin
    for (int i = 0; i < NUM; i++) begin fifo[i] = 0; pop_cnt[i] = 0; end
    repeat (3) tick();
    rst = 1'b0;
    tick();

    // Round-robin: all sources hold one word, then all refill once
    ready = 1'b1;
    gb = g_idx.size(); d0 = done_cnt; lb = lens.size();
    for (int i = 0; i < NUM; i++) fifo[i] = 1;
    drive_req();
    wait_done(d0 + 4, 40, "rr_round1_timeout");
    for (int i = 0; i < NUM; i++) fifo[i] = 1;
    drive_req();
    wait_done(d0 + 8, 60, "rr_round2_timeout");
    chk("rr_grant0", g_idx[gb + 0], 0);
    chk("rr_grant1", g_idx[gb + 1], 1);
    chk("rr_grant2", g_idx[gb + 2], 2);
    chk("rr_grant3", g_idx[gb + 3], 3);
    chk("rr_grant4", g_idx[gb + 4], 0);
    chk("rr_gap01", g_cyc[gb + 1] - g_cyc[gb + 0], 3);
    chk("rr_gap12", g_cyc[gb + 2] - g_cyc[gb + 1], 3);
    chk("rr_len", lens[lb], 1);

    // Drain: source 2 holds three words
    pc = pop_cnt[2]; d0 = done_cnt; lb = sop_cnt;
    fifo[2] = 3;
    drive_req();
    wait_done(d0 + 1, 20, "drain_timeout");
    chk("drain_pops", pop_cnt[2] - pc, 3);
    chk("drain_sops", sop_cnt - lb, 1);
    chk("drain_len", lens[lens.size() - 1], 3);
    chk("drain_idle_after", 32'(ena_bus), 32'd0);

    // Wrap: ptr sits at 3, only source 0 requests; then ptr=1 prefers source 1
    gb = g_idx.size(); d0 = done_cnt;
    fifo[0] = 1;
    drive_req();
    wait_done(d0 + 1, 20, "wrap_timeout");
    chk("wrap_grant", g_idx[gb], 0);
    fifo[0] = 1; fifo[1] = 1;
    drive_req();
    wait_done(d0 + 3, 30, "wrap_ptr_timeout");
    chk("wrap_ptr1_first", g_idx[gb + 1], 1);
    chk("wrap_ptr1_second", g_idx[gb + 2], 0);

    // Backpressure on source 1
    ready = 1'b0;
    fifo[1] = 10;
    drive_req();
    tick();
    chk("bp_granted", 32'(ena_bus), 32'b0010);
    pc = pop_cnt[1]; d0 = done_cnt;
    for (int k = 0; k < 5; k++) begin
      ready = bp_pat[k][0];
      tick();
    end
    chk("bp_pops", pop_cnt[1] - pc, 3);
    chk("bp_no_release", done_cnt - d0, 0);
    chk("bp_still_granted", 32'(ena_bus), 32'b0010);
    ready = 1'b1;
    fifo[1] = 0;
    drive_req();
    wait_done(d0 + 1, 10, "bp_timeout");
    chk("bp_len", lens[lens.size() - 1], 3);

    // Burst limit: sources 0 and 1 each hold six words
    gb = g_idx.size(); d0 = done_cnt; lb = lens.size();
    fifo[0] = 6; fifo[1] = 6;
    drive_req();
    wait_done(d0 + (LIM ? 4 : 2), 80, "limit_timeout");
    chk("limit_first_src", g_idx[gb], 0);
    chk("limit_second_src", g_idx[gb + 1], 1);
    chk("limit_len0", lens[lb], LIM ? 4 : 6);
    chk("limit_len1", lens[lb + 1], LIM ? 4 : 6);

    // Reset mid-burst, then grant latency from a fresh reset
    fifo[2] = 10;
    drive_req();
    tick(); tick(); tick();
    #2;
    rst = 1'b1;
    #1;
    chk("rst_ena_now", 32'(ena_bus), 32'd0);
    chk("rst_rdreq_now", 32'(rdreq), 32'd0);
    for (int i = 0; i < NUM; i++) fifo[i] = 0;
    drive_req();
    tick(); tick();
    rst = 1'b0;
    tick();
    d0 = done_cnt;
    fifo[0] = 1;
    drive_req();
    @(negedge clk);
    chk("lat_before", 32'(ena_bus), 32'd0);
    tick();
    @(negedge clk);
    chk("lat_ena", 32'(ena_bus), 32'b0001);
    chk("lat_rdreq", 32'(rdreq), 32'b0001);
    wait_done(d0 + 1, 10, "lat_timeout");
    tick(); tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1);
  end
endmodule
